// File: rtl/conv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : conv_pkg                                                   |
// | Description : Output mode encodings and reference Sobel kernels (KW=8)   |
// |               shared by the dual-kernel 3x3 convolution pipeline.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package conv_pkg;

    localparam logic [1:0] c_MODE_ABS_X = 2'd0;
    localparam logic [1:0] c_MODE_ABS_Y = 2'd1;
    localparam logic [1:0] c_MODE_L1    = 2'd2;
    localparam logic [1:0] c_MODE_SGN_X = 2'd3;

    // Coefficient k00 sits in the LSBs, k22 in the MSBs (row-major).
    localparam logic [71:0] c_SOBEL_X = {8'h01, 8'h00, 8'hFF,
                                         8'h02, 8'h00, 8'hFE,
                                         8'h01, 8'h00, 8'hFF};
    localparam logic [71:0] c_SOBEL_Y = {8'h01, 8'h02, 8'h01,
                                         8'h00, 8'h00, 8'h00,
                                         8'hFF, 8'hFE, 8'hFF};

endpackage
`default_nettype wire

// File: rtl/conv3x3_dot.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : conv3x3_dot                                                |
// | Description : 3x3 window dot product: registered products (S1) and a    |
// |               registered signed sum (S2), both advancing on en.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module conv3x3_dot #(
    parameter int BITW = 8,
    parameter int KW   = 8,
    parameter int ACCW = 20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   in_valid,
    input  logic [9*BITW-1:0]      win,
    input  logic [9*KW-1:0]        k,
    output logic signed [ACCW-1:0] sum,
    output logic                   sum_valid
);

    localparam int c_PW = BITW + 1 + KW;

    logic signed [c_PW-1:0] w_prod [9];
    logic signed [c_PW-1:0] r_prod [9];
    logic                   r_prod_valid;
    logic signed [ACCW-1:0] w_sum;
    logic signed [ACCW-1:0] r_sum;
    logic                   r_sum_valid;

    // Pixels are unsigned: a zero MSB keeps them positive in the signed multiply.
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            w_prod[i] = c_PW'($signed({1'b0, win[i*BITW +: BITW]}))
                      * c_PW'($signed(k[i*KW +: KW]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod_valid <= 1'b0;
            for (int i = 0; i < 9; i++) r_prod[i] <= '0;
        end else if (en) begin
            r_prod_valid <= in_valid;
            for (int i = 0; i < 9; i++) r_prod[i] <= w_prod[i];
        end
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 9; i++) w_sum = w_sum + ACCW'(r_prod[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum       <= '0;
            r_sum_valid <= 1'b0;
        end else if (en) begin
            r_sum       <= w_sum;
            r_sum_valid <= r_prod_valid;
        end
    end

    assign sum       = r_sum;
    assign sum_valid = r_sum_valid;

endmodule
`default_nettype wire

// File: rtl/conv3x3_dual_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : conv3x3_dual_pipe                                          |
// | Description : Parallel Gx/Gy 3x3 convolution with selectable magnitude   |
// |               or offset-signed output, backpressure and clamp counter.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module conv3x3_dual_pipe
    import conv_pkg::*;
#(
    parameter int BITW    = 8,
    parameter int KW      = 8,
    parameter int ACCW    = 20,
    parameter int OUTW    = 8,
    parameter int NORM_SH = 3,
    parameter int GAIN_SH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [9*BITW-1:0] win,
    input  logic [9*KW-1:0]   kx,
    input  logic [9*KW-1:0]   ky,
    input  logic [1:0]        mode,
    output logic [OUTW-1:0]   out_pix,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              sat_clr,
    output logic [15:0]       sat_cnt
);

    // Two headroom bits cover |sx|+|sy| and the SGN_X offset before clamping.
    localparam int c_TW     = ACCW + 2 + GAIN_SH;
    localparam int c_RND_SH = (NORM_SH > 0) ? NORM_SH - 1 : 0;
    localparam logic signed [c_TW-1:0] c_RND = (NORM_SH > 0) ? c_TW'(1 << c_RND_SH) : c_TW'(0);
    localparam logic signed [c_TW-1:0] c_OFS = c_TW'(1 << (OUTW - 1));
    localparam logic signed [c_TW-1:0] c_MAX = c_TW'((1 << OUTW) - 1);

    logic                   w_en;
    logic                   w_accept;
    logic signed [ACCW-1:0] w_sx;
    logic signed [ACCW-1:0] w_sy;
    logic                   w_vx;
    logic                   w_vy;
    logic                   w_v2;
    logic [1:0]             r_mode_s1;
    logic [1:0]             r_mode_s2;
    logic signed [c_TW-1:0] w_ex;
    logic signed [c_TW-1:0] w_ey;
    logic signed [c_TW-1:0] w_abs_x;
    logic signed [c_TW-1:0] w_abs_y;
    logic signed [c_TW-1:0] w_a;
    logic signed [c_TW-1:0] w_shr;
    logic signed [c_TW-1:0] w_t;
    logic [OUTW-1:0]        w_pix;
    logic                   w_clamped;
    logic [OUTW-1:0]        r_out_pix;
    logic                   r_out_valid;
    logic [15:0]            r_sat_cnt;

    assign w_en     = ~r_out_valid | out_ready;
    assign in_ready = w_en & rst_n;
    assign w_accept = in_valid & in_ready;

    conv3x3_dot #(.BITW(BITW), .KW(KW), .ACCW(ACCW)) u_dot_x (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (w_en),
        .in_valid  (w_accept),
        .win       (win),
        .k         (kx),
        .sum       (w_sx),
        .sum_valid (w_vx)
    );

    conv3x3_dot #(.BITW(BITW), .KW(KW), .ACCW(ACCW)) u_dot_y (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (w_en),
        .in_valid  (w_accept),
        .win       (win),
        .k         (ky),
        .sum       (w_sy),
        .sum_valid (w_vy)
    );

    // Both lanes share en and in_valid, so their valids always agree.
    assign w_v2 = w_vx & w_vy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_s1 <= c_MODE_ABS_X;
            r_mode_s2 <= c_MODE_ABS_X;
        end else if (w_en) begin
            r_mode_s1 <= mode;
            r_mode_s2 <= r_mode_s1;
        end
    end

    assign w_ex    = c_TW'(w_sx);
    assign w_ey    = c_TW'(w_sy);
    assign w_abs_x = w_ex[c_TW-1] ? -w_ex : w_ex;
    assign w_abs_y = w_ey[c_TW-1] ? -w_ey : w_ey;

    always_comb begin
        case (r_mode_s2)
            c_MODE_ABS_X: w_a = w_abs_x;
            c_MODE_ABS_Y: w_a = w_abs_y;
            c_MODE_L1:    w_a = w_abs_x + w_abs_y;
            default:      w_a = w_ex;
        endcase
        w_shr = (w_a + c_RND) >>> NORM_SH;
        w_t   = w_shr <<< GAIN_SH;
        if (r_mode_s2 == c_MODE_SGN_X) w_t = w_t + c_OFS;

        w_pix     = w_t[OUTW-1:0];
        w_clamped = 1'b0;
        if (w_t[c_TW-1]) begin
            w_pix     = '0;
            w_clamped = 1'b1;
        end else if (w_t > c_MAX) begin
            w_pix     = '1;
            w_clamped = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_pix   <= '0;
        end else if (w_en) begin
            r_out_valid <= w_v2;
            if (w_v2) r_out_pix <= w_pix;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_cnt <= '0;
        end else if (sat_clr) begin
            r_sat_cnt <= '0;
        end else if (w_en && w_v2 && w_clamped && (r_sat_cnt != 16'hFFFF)) begin
            r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end

    assign out_pix   = r_out_pix;
    assign out_valid = r_out_valid;
    assign sat_cnt   = r_sat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_dual_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_conv3x3_dual_pipe                                       |
// | Description : Scoreboard bench for conv3x3_dual_pipe with Sobel kernels. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_conv3x3_dual_pipe;
    import conv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [71:0] win = '0;
    logic [71:0] kx = c_SOBEL_X;
    logic [71:0] ky = c_SOBEL_Y;
    logic [1:0]  mode = c_MODE_ABS_X;
    logic [7:0]  out_pix;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        sat_clr = 1'b0;
    logic [15:0] sat_cnt;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  mon_exp;
    logic [7:0]  p0;
    logic [71:0] w80;

    conv3x3_dual_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .win       (win),
        .kx        (kx),
        .ky        (ky),
        .mode      (mode),
        .out_pix   (out_pix),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat_clr   (sat_clr),
        .sat_cnt   (sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [71:0] mkwin(input logic [7:0] l, input logic [7:0] m, input logic [7:0] r);
        logic [71:0] w;
        w = '0;
        for (int row = 0; row < 3; row++) begin
            w[(row*3+0)*8 +: 8] = l;
            w[(row*3+1)*8 +: 8] = m;
            w[(row*3+2)*8 +: 8] = r;
        end
        return w;
    endfunction

    // Holds the window until accepted; the expected pixel joins the scoreboard at acceptance.
    task automatic send(input logic [71:0] w, input logic [1:0] m, input logic [7:0] e);
        win      = w;
        mode     = m;
        in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0d expected none", out_pix);
            end else begin
                mon_exp = exp_q.pop_front();
                check("out_pix", out_pix, mon_exp);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        w80 = '0;
        w80[71:64] = 8'd80;

        repeat (3) @(posedge clk); #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_pix", out_pix, 0);
        check("rst_sat_cnt", sat_cnt, 0);
        check("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Edge response and latency
        send(mkwin(8'd0, 8'd77, 8'd100), c_MODE_ABS_X, 8'd100);
        idle();
        @(negedge clk); check("lat_c1_valid", out_valid, 0);
        @(negedge clk); check("lat_c2_valid", out_valid, 0);
        @(negedge clk); check("lat_c3_valid", out_valid, 1);
        @(posedge clk); #1;
        drain();
        check("sat_after_t1", sat_cnt, 0);

        send(mkwin(8'd0, 8'd77, 8'd255), c_MODE_ABS_X, 8'd255);
        idle();
        drain();
        check("sat_after_clamp", sat_cnt, 1);

        send(mkwin(8'd100, 8'd77, 8'd0), c_MODE_SGN_X, 8'd28);
        send(mkwin(8'd60, 8'd60, 8'd60), c_MODE_SGN_X, 8'd128);
        idle();
        drain();

        // Mode travels with each window
        send(w80, c_MODE_ABS_X, 8'd20);
        send(w80, c_MODE_ABS_Y, 8'd20);
        send(w80, c_MODE_L1,    8'd40);
        send(w80, c_MODE_SGN_X, 8'd148);
        idle();
        drain();
        check("sat_after_modes", sat_cnt, 1);

        // Backpressure
        out_ready = 1'b0;
        fork
            begin
                for (int v = 10; v <= 50; v += 10)
                    send(mkwin(8'd0, 8'd77, 8'(v)), c_MODE_ABS_X, 8'(v));
                idle();
            end
            begin
                for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
                check("bp_valid_rise", out_valid, 1);
                p0 = out_pix;
                check("bp_first_pix", p0, 10);
                for (int n = 0; n < 6; n++) begin
                    check("bp_in_ready", in_ready, 0);
                    check("bp_pix_stable", out_pix, p0);
                    @(negedge clk);
                end
                check("bp_accepted", exp_q.size(), 3);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Clear wins over a same-cycle clamp
        send(mkwin(8'd0, 8'd77, 8'd255), c_MODE_ABS_X, 8'd255);
        idle();
        @(posedge clk); #1;
        sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        drain();
        check("sat_clr_wins", sat_cnt, 0);
        send(mkwin(8'd0, 8'd77, 8'd255), c_MODE_ABS_X, 8'd255);
        idle();
        drain();
        check("sat_after_clr", sat_cnt, 1);

        // Reset with two windows in flight
        out_ready = 1'b0;
        send(mkwin(8'd0, 8'd77, 8'd30), c_MODE_ABS_X, 8'd30);
        send(mkwin(8'd0, 8'd77, 8'd40), c_MODE_ABS_X, 8'd40);
        idle();
        @(posedge clk); #1;
        check("rst_pre_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_in_ready", in_ready, 0);
        check("rst_mid_pix", out_pix, 0);
        check("rst_mid_sat", sat_cnt, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (10) @(posedge clk); #1;
        check("rst_no_stale", out_valid, 0);

        // Counter saturation
        for (int i = 0; i < 65540; i++)
            send(mkwin(8'd0, 8'd77, 8'd255), c_MODE_ABS_X, 8'd255);
        idle();
        drain();
        check("sat_hold_ffff", sat_cnt, 16'hFFFF);

        check("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
